// File: rtl/uart_cmd_ctrl.sv
// UART command controller: decodes write/read frames from the UART receiver
// into register-file strobes and returns read data to the UART transmitter.
module uart_cmd_ctrl #(
  parameter int          ADDR_W        = 4,
  parameter logic [7:0]  WR_CMD        = 8'hAA,
  parameter logic [7:0]  RD_CMD        = 8'hBB,
  parameter int          FRAME_TIMEOUT = 1024,
  parameter int          RD_TIMEOUT    = 8
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic [7:0]        RX_P_DATA,
  input  logic              RX_D_VLD,
  output logic [ADDR_W-1:0] RF_Address,
  output logic              RF_WrEn,
  output logic [7:0]        RF_WrData,
  output logic              RF_RdEn,
  input  logic [7:0]        RF_RdData,
  input  logic              RF_RdData_Valid,
  output logic [7:0]        TX_P_DATA,
  output logic              TX_D_VLD,
  input  logic              TX_Busy,
  output logic              CMD_ERR
);

  localparam int MAX_TO = (FRAME_TIMEOUT > RD_TIMEOUT) ?
                          FRAME_TIMEOUT : RD_TIMEOUT;
  localparam int CW = $clog2(MAX_TO) + 1;
  localparam logic [CW-1:0] FT_LAST  = CW'(FRAME_TIMEOUT - 1);
  localparam logic [CW-1:0] RT_LAST  = CW'(RD_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     fcnt_q, fcnt_d;
  logic [CW-1:0]     rcnt_q, rcnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        txd_q, txd_d;
  logic              wren_q, wren_d;
  logic              rden_q, rden_d;
  logic              txv_q, txv_d;
  logic              err_q, err_d;

  // State, counters and every output are registered together.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
      rcnt_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      txd_q   <= '0;
      wren_q  <= 1'b0;
      rden_q  <= 1'b0;
      txv_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      rcnt_q  <= rcnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      txd_q   <= txd_d;
      wren_q  <= wren_d;
      rden_q  <= rden_d;
      txv_q   <= txv_d;
      err_q   <= err_d;
    end
  end

  // Next-state, counter and strobe decode; an accepted byte or read
  // response wins over a timeout falling in the same cycle.
  always_comb begin
    state_d = state_q;
    fcnt_d  = (fcnt_q == CNT_MAX) ? fcnt_q : fcnt_q + 1'b1;
    rcnt_d  = (rcnt_q == CNT_MAX) ? rcnt_q : rcnt_q + 1'b1;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    txd_d   = txd_q;
    wren_d  = 1'b0;
    rden_d  = 1'b0;
    txv_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        fcnt_d = '0;
        rcnt_d = '0;
        if (RX_D_VLD) begin
          if (RX_P_DATA == WR_CMD) begin
            state_d = WR_ADDR;
          end else if (RX_P_DATA == RD_CMD) begin
            state_d = RD_ADDR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      WR_ADDR: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR_W-1:0];
          fcnt_d  = '0;
          state_d = WR_DATA;
        end else if (fcnt_q == FT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      WR_DATA: begin
        if (RX_D_VLD) begin
          wdata_d = RX_P_DATA;
          wren_d  = 1'b1;
          fcnt_d  = '0;
          state_d = IDLE;
        end else if (fcnt_q == FT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      RD_ADDR: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR_W-1:0];
          rden_d  = 1'b1;
          fcnt_d  = '0;
          rcnt_d  = '0;
          state_d = RD_WAIT;
        end else if (fcnt_q == FT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      RD_WAIT: begin
        if (RF_RdData_Valid) begin
          txd_d   = RF_RdData;
          state_d = TX_HOLD;
        end else if (rcnt_q == RT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      TX_HOLD: begin
        if (!TX_Busy) begin
          txv_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign RF_Address = addr_q;
  assign RF_WrData  = wdata_q;
  assign RF_WrEn    = wren_q;
  assign RF_RdEn    = rden_q;
  assign TX_P_DATA  = txd_q;
  assign TX_D_VLD   = txv_q;
  assign CMD_ERR    = err_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: frame table plus timeout,
// busy-hold, dropped-byte and reset sequences.
module tb_uart_cmd_ctrl;

  localparam int FT = 1024;
  localparam int RT = 8;

  logic       CLK = 1'b0;
  logic       RST_n;
  logic [7:0] RX_P_DATA;
  logic       RX_D_VLD;
  logic [3:0] RF_Address;
  logic       RF_WrEn;
  logic [7:0] RF_WrData;
  logic       RF_RdEn;
  logic [7:0] RF_RdData;
  logic       RF_RdData_Valid;
  logic [7:0] TX_P_DATA;
  logic       TX_D_VLD;
  logic       TX_Busy;
  logic       CMD_ERR;

  uart_cmd_ctrl dut (
    .CLK(CLK), .RST_n(RST_n),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RF_Address(RF_Address), .RF_WrEn(RF_WrEn),
    .RF_WrData(RF_WrData), .RF_RdEn(RF_RdEn),
    .RF_RdData(RF_RdData), .RF_RdData_Valid(RF_RdData_Valid),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
    .TX_Busy(TX_Busy), .CMD_ERR(CMD_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] op, addr, data;
    int gap, lat;
    int e_wr, e_rd, e_tx, e_err;
    logic [7:0] e_addr, e_data;
  } vec_t;

  vec_t tv[9];

  int n_vec = 0;
  int n_err = 0;
  int wr_n, rd_n, tx_n, err_n;
  logic [7:0] cap_addr, cap_wdata, cap_tx;
  int rd_lat = 0;
  logic [7:0] rd_val = 8'h00;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr();
    wr_n = 0; rd_n = 0; tx_n = 0; err_n = 0;
    cap_addr = 8'h00; cap_wdata = 8'h00; cap_tx = 8'h00;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge CLK);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(negedge CLK);
    RX_D_VLD  = 1'b0;
    repeat (gap) @(negedge CLK);
  endtask

  // Output monitor: counts strobes, captures values, checks exclusivity.
  initial begin
    clr();
    forever begin
      @(posedge CLK);
      #1;
      if (RF_WrEn) begin
        wr_n++; cap_addr = 8'(RF_Address); cap_wdata = RF_WrData;
      end
      if (RF_RdEn) begin
        rd_n++; cap_addr = 8'(RF_Address);
      end
      if (TX_D_VLD) begin
        tx_n++; cap_tx = TX_P_DATA;
      end
      if (CMD_ERR) err_n++;
      if (32'(RF_WrEn) + 32'(RF_RdEn) + 32'(TX_D_VLD) + 32'(CMD_ERR) > 1) begin
        n_vec++; n_err++;
        $display("FAIL exclusive: wr=%0b rd=%0b tx=%0b err=%0b",
                 RF_WrEn, RF_RdEn, TX_D_VLD, CMD_ERR);
      end
    end
  end

  // Register-file responder: answers a read strobe rd_lat cycles later.
  initial begin
    RF_RdData = 8'h00;
    RF_RdData_Valid = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      if (RF_RdEn && rd_lat != 0) begin
        repeat (rd_lat + 1) @(negedge CLK);
        RF_RdData = rd_val;
        RF_RdData_Valid = 1'b1;
        @(negedge CLK);
        RF_RdData_Valid = 1'b0;
      end
    end
  end

  initial begin
    int nb, n, k;
    tv[0] = '{8'hAA, 8'h03, 8'h5C, 20, 0, 1, 0, 0, 0, 8'h03, 8'h5C};
    tv[1] = '{8'hAA, 8'hFA, 8'h01,  0, 0, 1, 0, 0, 0, 8'h0A, 8'h01};
    tv[2] = '{8'hAA, 8'h00, 8'hFF,  3, 0, 1, 0, 0, 0, 8'h00, 8'hFF};
    tv[3] = '{8'hBB, 8'h07, 8'hC3,  0, 2, 0, 1, 1, 0, 8'h07, 8'hC3};
    tv[4] = '{8'hBB, 8'h1F, 8'h5A,  5, 1, 0, 1, 1, 0, 8'h0F, 8'h5A};
    tv[5] = '{8'hBB, 8'h05, 8'h96,  0, 7, 0, 1, 1, 0, 8'h05, 8'h96};
    tv[6] = '{8'hBB, 8'h0E, 8'h69,  0, 8, 0, 1, 0, 1, 8'h0E, 8'h00};
    tv[7] = '{8'h11, 8'h00, 8'h00,  0, 0, 0, 0, 0, 1, 8'h00, 8'h00};
    tv[8] = '{8'h00, 8'h00, 8'h00,  0, 0, 0, 0, 0, 1, 8'h00, 8'h00};

    RST_n = 1'b0; RX_P_DATA = 8'h00; RX_D_VLD = 1'b0; TX_Busy = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_outs", {RF_Address, RF_WrEn, RF_WrData, RF_RdEn,
                       TX_P_DATA, TX_D_VLD, CMD_ERR}, 0);
    RST_n = 1'b1;
    repeat (2) @(negedge CLK);

    for (int i = 0; i < 9; i++) begin
      clr();
      rd_lat = tv[i].lat;
      rd_val = tv[i].data;
      nb = (tv[i].op == 8'hAA) ? 3 : (tv[i].op == 8'hBB) ? 2 : 1;
      send_byte(tv[i].op, tv[i].gap);
      if (nb > 1) send_byte(tv[i].addr, tv[i].gap);
      if (nb > 2) send_byte(tv[i].data, tv[i].gap);
      repeat (30) @(negedge CLK);
      chk($sformatf("v%0d_wr", i), wr_n, tv[i].e_wr);
      chk($sformatf("v%0d_rd", i), rd_n, tv[i].e_rd);
      chk($sformatf("v%0d_tx", i), tx_n, tv[i].e_tx);
      chk($sformatf("v%0d_err", i), err_n, tv[i].e_err);
      if (tv[i].e_wr + tv[i].e_rd > 0)
        chk($sformatf("v%0d_addr", i), cap_addr, tv[i].e_addr);
      if (tv[i].e_wr > 0)
        chk($sformatf("v%0d_wdata", i), cap_wdata, tv[i].e_data);
      if (tv[i].e_tx > 0)
        chk($sformatf("v%0d_txdata", i), cap_tx, tv[i].e_data);
    end
    rd_lat = 0;

    // Transmitter busy holds the response until it drops.
    clr();
    rd_lat = 2; rd_val = 8'hC3; TX_Busy = 1'b1;
    send_byte(8'hBB, 0);
    send_byte(8'h07, 0);
    repeat (50) @(negedge CLK);
    chk("busy_hold_tx", tx_n, 0);
    TX_Busy = 1'b0;
    @(posedge CLK); #1;
    chk("busy_release_vld", TX_D_VLD, 1);
    chk("busy_release_data", TX_P_DATA, 8'hC3);
    repeat (5) @(negedge CLK);
    chk("busy_tx_count", tx_n, 1);
    rd_lat = 0;

    // Bad opcode, then a write frame abandoned after the opcode.
    clr();
    send_byte(8'h11, 3);
    chk("badop_err", err_n, 1);
    send_byte(8'hAA, 0);
    n = 0;
    while (!CMD_ERR && n < 2 * FT) begin
      @(posedge CLK); #1; n++;
    end
    chk("frame_to_cycles", n, FT);
    repeat (3) @(negedge CLK);
    chk("frame_to_wr", wr_n, 0);
    chk("frame_to_errs", err_n, 2);
    send_byte(8'h22, 3);
    chk("frame_to_idle", err_n, 3);

    // Byte arriving on the timeout cycle is still accepted.
    clr();
    send_byte(8'hAA, 0);
    repeat (FT - 2) @(negedge CLK);
    send_byte(8'h09, 0);
    send_byte(8'h77, 5);
    chk("edge_err", err_n, 0);
    chk("edge_wr", wr_n, 1);
    chk("edge_addr", cap_addr, 8'h09);
    chk("edge_wdata", cap_wdata, 8'h77);

    // Read that never returns data.
    clr();
    send_byte(8'hBB, 0);
    send_byte(8'h02, 0);
    k = 0;
    while (!RF_RdEn && k < 20) begin
      @(posedge CLK); #1; k++;
    end
    n = 0;
    while (!CMD_ERR && n < 50) begin
      @(posedge CLK); #1; n++;
    end
    chk("rd_to_cycles", n, RT);
    repeat (5) @(negedge CLK);
    chk("rd_to_tx", tx_n, 0);
    chk("rd_to_addr", cap_addr, 8'h02);

    // Byte during read wait is dropped.
    clr();
    rd_lat = 5; rd_val = 8'h81;
    send_byte(8'hBB, 0);
    send_byte(8'h06, 0);
    send_byte(8'hAA, 20);
    send_byte(8'h11, 5);
    chk("drop_tx", tx_n, 1);
    chk("drop_txdata", cap_tx, 8'h81);
    chk("drop_err", err_n, 1);
    chk("drop_wr", wr_n, 0);
    rd_lat = 0;

    // Reset mid-frame clears everything.
    clr();
    send_byte(8'hAA, 0);
    send_byte(8'h04, 2);
    RST_n = 1'b0;
    #1;
    chk("rst_addr", RF_Address, 0);
    chk("rst_outs", {RF_WrEn, RF_WrData, RF_RdEn,
                     TX_P_DATA, TX_D_VLD, CMD_ERR}, 0);
    @(negedge CLK);
    RST_n = 1'b1;
    @(negedge CLK);
    rd_lat = 2; rd_val = 8'h3C;
    send_byte(8'hBB, 0);
    send_byte(8'h04, 30);
    chk("rst_wr", wr_n, 0);
    chk("rst_rd", rd_n, 1);
    chk("rst_rdaddr", cap_addr, 8'h04);
    chk("rst_tx", cap_tx, 8'h3C);
    chk("rst_err", err_n, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 Parameter ADDR_W, default 4, register-file address width.
REQ-002 Parameter WR_CMD, default 8'hAA, write-command opcode byte.
REQ-003 Parameter RD_CMD, default 8'hBB, read-command opcode byte.
REQ-004 Parameter FRAME_TIMEOUT, default 1024, max cycles allowed between bytes of one command frame.
REQ-005 Parameter RD_TIMEOUT, default 8, max cycles allowed from RF_RdEn to RF_RdData_Valid.
REQ-006 CLK  in  1  sole clock, all state updates on rising edge.
REQ-007 RST_n  in  1  asynchronous, active-low reset.
REQ-008 RX_P_DATA  in  8  received byte from the UART receiver.
REQ-009 RX_D_VLD  in  1  one-cycle pulse marking RX_P_DATA valid.
REQ-010 RF_Address  out  ADDR_W  register-file address.
REQ-011 RF_WrEn  out  1  one-cycle write strobe.
REQ-012 RF_WrData  out  8  register-file write data.
REQ-013 RF_RdEn  out  1  one-cycle read strobe.
REQ-014 RF_RdData  in  8  register-file read data.
REQ-015 RF_RdData_Valid  in  1  one-cycle pulse marking RF_RdData valid.
REQ-016 TX_P_DATA  out  8  byte handed to the UART transmitter.
REQ-017 TX_D_VLD  out  1  one-cycle pulse marking TX_P_DATA valid.
REQ-018 TX_Busy  in  1  transmitter busy; no TX_D_VLD while high.
REQ-019 CMD_ERR  out  1  one-cycle pulse on bad opcode or any timeout.

Function
REQ-020 The FSM SHALL have states IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_HOLD; all outputs registered.
REQ-021 IDLE: on RX_D_VLD with byte==WR_CMD go WR_ADDR; byte==RD_CMD go RD_ADDR; any other byte pulse CMD_ERR next cycle, stay IDLE.
REQ-022 WR_ADDR: on RX_D_VLD latch RF_Address=RX_P_DATA[ADDR_W-1:0] (upper bits discarded), go WR_DATA.
REQ-023 WR_DATA: on RX_D_VLD drive RF_WrData=RX_P_DATA and RF_WrEn=1 for exactly the next cycle, go IDLE.
REQ-024 RD_ADDR: on RX_D_VLD latch RF_Address, drive RF_RdEn=1 for exactly the next cycle, go RD_WAIT.
REQ-025 RD_WAIT: on RF_RdData_Valid latch RF_RdData into TX_P_DATA, go TX_HOLD; RF_RdData_Valid in any other state ignored.
REQ-026 TX_HOLD: first cycle TX_Busy==0, pulse TX_D_VLD one cycle with TX_P_DATA stable, go IDLE; TX_Busy high holds indefinitely, no timeout.
REQ-027 Frame counter SHALL clear on entry to WR_ADDR/WR_DATA/RD_ADDR and on each accepted byte, increment otherwise; reaching FRAME_TIMEOUT-1 without RX_D_VLD pulses CMD_ERR, returns IDLE, no RF strobe.
REQ-028 Read counter SHALL clear on entry to RD_WAIT; reaching RD_TIMEOUT-1 without RF_RdData_Valid pulses CMD_ERR, returns IDLE, no TX_D_VLD.
REQ-029 Counter widths SHALL be $clog2(max timeout)+1 bits; counters SHALL saturate, never wrap.
REQ-030 RX_D_VLD coincident with the timeout cycle: byte accepted, timeout not taken, no CMD_ERR.
REQ-031 RX_D_VLD during RD_WAIT or TX_HOLD SHALL be dropped without error and without state change.
REQ-032 RF_WrEn and RF_RdEn SHALL never be high together; at most one of RF_WrEn, RF_RdEn, TX_D_VLD, CMD_ERR high per cycle.
REQ-033 RF_Address, RF_WrData, TX_P_DATA SHALL hold last values between strobes.

Reset
REQ-034 RST_n low SHALL asynchronously force IDLE, clear both counters and drive all outputs to 0, including mid-frame and mid-TX_HOLD.
REQ-035 After RST_n deasserts, the first byte accepted SHALL be interpreted as an opcode.

Verification
REQ-036 Bytes AA,03,5C with 20-cycle gaps -> RF_WrEn one cycle, RF_Address=3, RF_WrData=5C, back to IDLE, CMD_ERR never high.
REQ-037 Bytes BB,07; RF_RdData=C3 valid 2 cycles after RF_RdEn; TX_Busy=0 -> RF_RdEn one cycle at addr 7, then TX_D_VLD one cycle with TX_P_DATA=C3.
REQ-038 Read as above with TX_Busy=1 for 50 cycles -> TX_D_VLD asserted in first cycle after TX_Busy falls, not before.
REQ-039 Byte 11 in IDLE -> CMD_ERR one cycle; then AA only, no further bytes for FRAME_TIMEOUT cycles -> CMD_ERR, no RF_WrEn, IDLE.
REQ-040 Bytes BB,02 with RF_RdData_Valid never asserted -> CMD_ERR exactly RD_TIMEOUT cycles after RF_RdEn, no TX_D_VLD.
REQ-041 RST_n low after AA,04 -> all outputs 0 immediately; next bytes BB,04 executed as read, no stale write.
